// File: rtl/axi_slave_write_ctrl.sv
// AXI4 write-channel front end: one AW burst at a time, W beats -> registered memory write pulses, one B per burst.
// Optional AXI_WLAST_CHECK_EN: a WLAST that disagrees with the beat count turns the response into SLVERR.
module axi_slave_write_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 1,
  parameter int MEM_AW = 12
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic [ID_W-1:0]     S_AXI_AWID,
  input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
  input  logic [7:0]          S_AXI_AWLEN,
  input  logic [2:0]          S_AXI_AWSIZE,
  input  logic [1:0]          S_AXI_AWBURST,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [DATA_W-1:0]   S_AXI_WDATA,
  input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
  input  logic                S_AXI_WLAST,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  output logic [ID_W-1:0]     S_AXI_BID,
  output logic [1:0]          S_AXI_BRESP,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  output logic                mem_we,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb
);
  localparam int STRB_W = DATA_W / 8;
  localparam int ALSB   = (DATA_W == 64) ? 3 : 2;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
  state_t state, state_nx;

  logic [ID_W-1:0]   id_q;
  logic [7:0]        len_q;
  logic [1:0]        burst_q;
  logic [ADDR_W-1:0] addr_q, size_b, wrap_lo, wrap_hi, addr_nx;
  logic [7:0]        cnt;
  logic              aw_err, err;

  logic aw_hs, w_hs, b_hs, last_beat;
  assign aw_hs     = S_AXI_AWVALID && (state == IDLE);
  assign w_hs      = S_AXI_WVALID && (state == DATA);
  assign b_hs      = S_AXI_BREADY && (state == RESP);
  assign last_beat = (cnt == len_q);

  // Burst geometry is derived from the AW beat so the per-beat update is a single add/compare.
  logic [ADDR_W-1:0] size_b_in, wrap_b_in;
  logic              aw_err_in;
  assign size_b_in = ADDR_W'(1) << S_AXI_AWSIZE;
  assign wrap_b_in = size_b_in * (ADDR_W'(S_AXI_AWLEN) + ADDR_W'(1));
  assign aw_err_in = (S_AXI_AWBURST == 2'b11)
                  || ((S_AXI_AWBURST == BURST_WRAP) && (S_AXI_AWLEN != 8'd1) && (S_AXI_AWLEN != 8'd3)
                      && (S_AXI_AWLEN != 8'd7) && (S_AXI_AWLEN != 8'd15))
                  || (S_AXI_AWSIZE > 3'(ALSB));

  always_comb begin
    addr_nx = addr_q + size_b;
    if (burst_q == BURST_FIXED) addr_nx = addr_q;
    else if ((burst_q == BURST_WRAP) && (addr_nx == wrap_hi)) addr_nx = wrap_lo;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (aw_hs) state_nx = DATA;
      DATA:    if (w_hs && last_beat) state_nx = RESP;
      RESP:    if (b_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      id_q      <= '0;
      len_q     <= '0;
      burst_q   <= '0;
      addr_q    <= '0;
      size_b    <= '0;
      wrap_lo   <= '0;
      wrap_hi   <= '0;
      cnt       <= '0;
      aw_err    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      mem_we <= 1'b0;
      if (aw_hs) begin
        id_q    <= S_AXI_AWID;
        len_q   <= S_AXI_AWLEN;
        burst_q <= S_AXI_AWBURST;
        addr_q  <= S_AXI_AWADDR;
        size_b  <= size_b_in;
        wrap_lo <= S_AXI_AWADDR & ~(wrap_b_in - ADDR_W'(1));
        wrap_hi <= (S_AXI_AWADDR & ~(wrap_b_in - ADDR_W'(1))) + wrap_b_in;
        cnt     <= '0;
        aw_err  <= aw_err_in;
      end
      if (w_hs) begin
        mem_we    <= !aw_err;
        mem_addr  <= MEM_AW'(addr_q >> ALSB);
        mem_wdata <= S_AXI_WDATA;
        mem_wstrb <= S_AXI_WSTRB[STRB_W-1:0];
        addr_q    <= addr_nx;
        cnt       <= cnt + 8'd1;
      end
    end
  end

`ifdef AXI_WLAST_CHECK_EN
  logic wl_err;
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                            wl_err <= 1'b0;
    else if (aw_hs)                          wl_err <= 1'b0;
    else if (w_hs && (S_AXI_WLAST != last_beat)) wl_err <= 1'b1;
  end
  assign err = aw_err || wl_err;
`else
  logic wlast_unused;
  assign wlast_unused = S_AXI_WLAST;
  assign err = aw_err;
`endif

  assign S_AXI_AWREADY = (state == IDLE);
  assign S_AXI_WREADY  = (state == DATA);
  assign S_AXI_BVALID  = (state == RESP);
  assign S_AXI_BID     = id_q;
  assign S_AXI_BRESP   = ((state == RESP) && err) ? 2'b10 : 2'b00;
endmodule

// File: tb/tb_axi_slave_write_ctrl.sv
// Directed bench for axi_slave_write_ctrl: burst types, address sequencing, error responses, async reset.
module tb_axi_slave_write_ctrl;
  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [0:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [0:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  axi_slave_write_ctrl dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
    .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready), .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; handshake happens on the next edge since AWREADY is high in IDLE.
  task automatic do_aw(input logic [0:0] id, input logic [31:0] a, input logic [7:0] len,
                       input logic [2:0] sz, input logic [1:0] bt);
    awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bt; awvalid = 1'b1;
    @(posedge ACLK); #1;
    awvalid = 1'b0;
    chk("aw_awready_low", {63'd0, awready}, 64'd0);
    chk("aw_wready_high", {63'd0, wready}, 64'd1);
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s, input logic last,
                      input logic exp_we, input logic [11:0] exp_addr);
    wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
    @(posedge ACLK); #1;
    wvalid = 1'b0; wlast = 1'b0;
    chk("w_mem_we", {63'd0, mem_we}, {63'd0, exp_we});
    if (exp_we) begin
      chk("w_mem_addr", {52'd0, mem_addr}, {52'd0, exp_addr});
      chk("w_mem_wdata", {32'd0, mem_wdata}, {32'd0, d});
      chk("w_mem_wstrb", {60'd0, mem_wstrb}, {60'd0, s});
    end
  endtask

  task automatic do_b(input logic [0:0] exp_id, input logic [1:0] exp_resp, input int delay);
    chk("b_bvalid", {63'd0, bvalid}, 64'd1);
    chk("b_bid", {63'd0, bid}, {63'd0, exp_id});
    chk("b_bresp", {62'd0, bresp}, {62'd0, exp_resp});
    for (int i = 0; i < delay; i++) begin
      @(posedge ACLK); #1;
      chk("b_hold_bvalid", {63'd0, bvalid}, 64'd1);
      chk("b_hold_bresp", {62'd0, bresp}, {62'd0, exp_resp});
      chk("b_hold_awready", {63'd0, awready}, 64'd0);
    end
    bready = 1'b1;
    @(posedge ACLK); #1;
    bready = 1'b0;
    chk("b_done_bvalid", {63'd0, bvalid}, 64'd0);
    chk("b_done_awready", {63'd0, awready}, 64'd1);
  endtask

  initial begin
    ARESETN = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    chk("rst_awready", {63'd0, awready}, 64'd1);
    chk("rst_wready", {63'd0, wready}, 64'd0);
    chk("rst_bvalid", {63'd0, bvalid}, 64'd0);
    chk("rst_bresp", {62'd0, bresp}, 64'd0);
    chk("rst_bid", {63'd0, bid}, 64'd0);
    chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
    chk("rst_mem_addr", {52'd0, mem_addr}, 64'd0);
    chk("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
    ARESETN = 1'b1;
    @(posedge ACLK); #1;

    // W presented before any AW must wait
    wvalid = 1'b1; wdata = 32'h1111_2222; wstrb = 4'hF;
    @(posedge ACLK); #1;
    chk("idle_wready", {63'd0, wready}, 64'd0);
    @(posedge ACLK); #1;
    chk("idle_no_we", {63'd0, mem_we}, 64'd0);
    wvalid = 1'b0;

    // single INCR beat
    do_aw(1'b1, 32'h100, 8'd0, 3'd2, 2'b01);
    do_w(32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 12'h040);
    do_b(1'b1, 2'b00, 0);

    // INCR 4 beats
    do_aw(1'b0, 32'h0, 8'd3, 3'd2, 2'b01);
    do_w(32'hA000_0000, 4'hF, 1'b0, 1'b1, 12'd0);
    do_w(32'hA000_0001, 4'h3, 1'b0, 1'b1, 12'd1);
    do_w(32'hA000_0002, 4'hC, 1'b0, 1'b1, 12'd2);
    chk("incr_no_b_early", {63'd0, bvalid}, 64'd0);
    do_w(32'hA000_0003, 4'hF, 1'b1, 1'b1, 12'd3);
    do_b(1'b0, 2'b00, 0);

    // WRAP 4 beats from 0x18: 0x18, 0x1C, 0x10, 0x14
    do_aw(1'b1, 32'h18, 8'd3, 3'd2, 2'b10);
    do_w(32'hB000_0000, 4'hF, 1'b0, 1'b1, 12'd6);
    do_w(32'hB000_0001, 4'hF, 1'b0, 1'b1, 12'd7);
    do_w(32'hB000_0002, 4'hF, 1'b0, 1'b1, 12'd4);
    do_w(32'hB000_0003, 4'hF, 1'b1, 1'b1, 12'd5);
    do_b(1'b1, 2'b00, 0);

    // FIXED 3 beats with 2-cycle W gaps, delayed BREADY
    do_aw(1'b0, 32'h20, 8'd2, 3'd2, 2'b00);
    for (int b = 0; b < 3; b++) begin
      do_w(32'hC000_0000 + 32'(b), 4'hF, b == 2, 1'b1, 12'd8);
      if (b < 2) begin
        repeat (2) begin
          @(posedge ACLK); #1;
          chk("fixed_gap_no_we", {63'd0, mem_we}, 64'd0);
          chk("fixed_gap_wready", {63'd0, wready}, 64'd1);
        end
      end
    end
    do_b(1'b0, 2'b00, 5);

    // illegal WRAP length: beats consumed, nothing written, SLVERR
    do_aw(1'b1, 32'h0, 8'd2, 3'd2, 2'b10);
    do_w(32'hE000_0000, 4'hF, 1'b0, 1'b0, 12'd0);
    do_w(32'hE000_0001, 4'hF, 1'b0, 1'b0, 12'd0);
    do_w(32'hE000_0002, 4'hF, 1'b1, 1'b0, 12'd0);
    do_b(1'b1, 2'b10, 0);

    // legal INCR afterwards returns OKAY
    do_aw(1'b0, 32'h8, 8'd1, 3'd2, 2'b01);
    do_w(32'hF000_0000, 4'hF, 1'b0, 1'b1, 12'd2);
    do_w(32'hF000_0001, 4'hF, 1'b1, 1'b1, 12'd3);
    do_b(1'b0, 2'b00, 0);

    // beat size wider than the bus is an error
    do_aw(1'b1, 32'h0, 8'd0, 3'd3, 2'b01);
    do_w(32'h5555_5555, 4'hF, 1'b1, 1'b0, 12'd0);
    do_b(1'b1, 2'b10, 0);

    // asynchronous reset after the 2nd beat of a LEN=7 burst
    do_aw(1'b1, 32'h40, 8'd7, 3'd2, 2'b01);
    do_w(32'h7000_0000, 4'hF, 1'b0, 1'b1, 12'h010);
    do_w(32'h7000_0001, 4'hF, 1'b0, 1'b1, 12'h011);
    #2 ARESETN = 1'b0;
    #1;
    chk("arst_mem_we", {63'd0, mem_we}, 64'd0);
    chk("arst_mem_addr", {52'd0, mem_addr}, 64'd0);
    chk("arst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
    chk("arst_awready", {63'd0, awready}, 64'd1);
    chk("arst_wready", {63'd0, wready}, 64'd0);
    chk("arst_bid", {63'd0, bid}, 64'd0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    repeat (2) begin
      @(posedge ACLK); #1;
      chk("arst_no_b", {63'd0, bvalid}, 64'd0);
    end

    // next burst after reset behaves normally
    do_aw(1'b0, 32'h200, 8'd1, 3'd2, 2'b01);
    do_w(32'h9000_0000, 4'hF, 1'b0, 1'b1, 12'h080);
    do_w(32'h9000_0001, 4'hF, 1'b1, 1'b1, 12'h081);
    do_b(1'b0, 2'b00, 0);

    // WLAST missing on the final beat
    do_aw(1'b1, 32'h300, 8'd1, 3'd2, 2'b01);
    do_w(32'h8000_0000, 4'hF, 1'b0, 1'b1, 12'h0C0);
    do_w(32'h8000_0001, 4'hF, 1'b0, 1'b1, 12'h0C1);
`ifdef AXI_WLAST_CHECK_EN
    do_b(1'b1, 2'b10, 0);
`else
    do_b(1'b1, 2'b00, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_slave_write_ctrl.md
Name: axi_slave_write_ctrl

Overview:
- Write-channel front end of the AXI4 memory-model slave. It sits directly downstream of the AXI4 master BFM's AW/W/B ports and upstream of the memory array.
- Accepts one AW burst at a time and sequences W beats into per-beat memory write strobes with computed addresses (FIXED/INCR/WRAP).
- Returns one B response per burst.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be 32 or 64
- ID_W, 1, AWID/BID width
- MEM_AW, 12, memory word-address width; mem_addr = byte address >> log2(DATA_W/8), truncated

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWID  in  ID_W  write ID
- S_AXI_AWADDR  in  ADDR_W  start byte address
- S_AXI_AWLEN  in  8  beats-1
- S_AXI_AWSIZE  in  3  bytes/beat = 2^AWSIZE
- S_AXI_AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP
- S_AXI_AWVALID  in  1  address valid
- S_AXI_AWREADY  out  1  address ready
- S_AXI_WDATA  in  DATA_W  write data
- S_AXI_WSTRB  in  DATA_W/8  byte strobes
- S_AXI_WLAST  in  1  last beat
- S_AXI_WVALID  in  1  data valid
- S_AXI_WREADY  out  1  data ready
- S_AXI_BID  out  ID_W  response ID
- S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR
- S_AXI_BVALID  out  1  response valid
- S_AXI_BREADY  in  1  response ready
- mem_we  out  1  one-cycle write pulse per accepted beat
- mem_addr  out  MEM_AW  word address
- mem_wdata  out  DATA_W  registered WDATA
- mem_wstrb  out  DATA_W/8  registered WSTRB

Behaviour:
- Reset (ARESETN low, asynchronous): state=IDLE; AWREADY=1; WREADY=0; BVALID=0; BRESP=00; BID=0; mem_we=0; mem_addr=0; mem_wdata=0; mem_wstrb=0; beat counter=0; error flag=0.
- FSM IDLE -> DATA on AWVALID&AWREADY:
  - Latch ID, ADDR, LEN, SIZE, BURST.
  - Next cycle: AWREADY=0, WREADY=1.
- Errors latched at AW accept:
  - BURST=11 -> error.
  - WRAP with LEN not in {1,3,7,15} -> error.
  - 2^AWSIZE > DATA_W/8 -> error.
  - The beats are still accepted, but mem_we stays 0 for the whole burst.
- DATA: each WVALID&WREADY is one beat.
  - mem_we=1 on the following cycle, with mem_addr/wdata/wstrb registered from that beat. Latency is 1 cycle.
  - Counter increments. The beat with count==LEN is last -> RESP next cycle, WREADY=0.
- Address update after each beat, in ADDR_W-bit modulo arithmetic, size bytes = 2^SIZE:
  - FIXED: unchanged.
  - INCR: addr += size.
  - WRAP: boundary = (ADDR/(size*(LEN+1)))*(size*(LEN+1)). addr += size; if addr == boundary + size*(LEN+1), then addr = boundary.
  - INCR across a 4 KB boundary is not checked; the address continues linearly.
- RESP: BVALID=1, BID=latched ID, BRESP=10 if error else 00.
  - Hold until BREADY. On BVALID&BREADY -> IDLE; BVALID=0 and AWREADY=1 next cycle.
  - BREADY already high on entry completes the handshake in 1 cycle.
- AWVALID outside IDLE: ignored, AWREADY=0. Only one burst is outstanding.
- WVALID in IDLE: not accepted, WREADY=0. W before AW waits.
- Reset mid-burst: burst abandoned, no B response, all outputs return to reset values immediately.

Optional Feature:
- Macro AXI_WLAST_CHECK_EN.
- Defined:
  - WLAST=1 on a non-final beat, or WLAST=0 on the final beat, sets the error flag -> BRESP=10. Writes already performed stand.
  - A premature WLAST does not end the burst early; the count governs.
- Undefined: WLAST ignored entirely; BRESP depends only on the AW errors.

Test Plan:
- Single INCR: AW addr=0x100, LEN=0, SIZE=2, ID=1; W 0xDEADBEEF, strb=F -> one mem_we, mem_addr=0x40, wdata=0xDEADBEEF; BID=1, BRESP=00.
- INCR 4 beats: addr=0x0, LEN=3, SIZE=2 -> mem_addr 0,1,2,3 on consecutive pulses; single B OKAY after the 4th beat.
- WRAP 4: addr=0x18, LEN=3, SIZE=2 -> byte addresses 0x18, 0x1C, 0x10, 0x14 (mem_addr 6,7,4,5).
- FIXED 3 beats at 0x20 with WVALID gaps of 2 cycles -> mem_addr 8 three times, one pulse per accepted beat; BREADY delayed 5 cycles -> BVALID held stable, AWREADY=0 throughout.
- Error: WRAP LEN=2 -> 3 beats accepted, no mem_we, BRESP=10. Then a legal INCR burst -> BRESP=00.
- Reset pulse after the 2nd beat of LEN=7 -> outputs reset asynchronously, no B response. The next burst behaves normally. With AXI_WLAST_CHECK_EN defined, WLAST missing on the last beat -> BRESP=10.
